// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult_if
// Description : Start/busy/done handshake and operand/product bus for the
//               sequential Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                   input_signal;
  logic                   sgn;
  logic [WIDTH-1:0]       M;
  logic [WIDTH-1:0]       Q;
  logic [2*WIDTH-1:0]     out;
  logic                   busy;
  logic                   done;

  // Requester side: issues operands and the start strobe
  modport master (
    output input_signal, sgn, M, Q,
    input  out, busy, done
  );

  // Multiplier side: consumes operands, returns product and status
  modport slave (
    input  input_signal, sgn, M, Q,
    output out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult
// Description : Sequential radix-2 Booth multiplier, WIDTH-bit operands,
//               2*WIDTH-bit product, signed or unsigned mode, one Booth step
//               per clock (WIDTH+1 steps per product).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  booth_seq_mult_if.slave   bus
);

  // Operands are extended by one bit so a single signed core covers both
  // signed and unsigned modes.
  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);
  localparam logic [CW-1:0] c_LAST = CW'(E - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [E-1:0]        r_a, w_a_nxt;
  logic [E-1:0]        r_m, w_m_nxt;
  logic [E-1:0]        r_q, w_q_nxt;
  logic                r_q1, w_q1_nxt;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic [2*WIDTH-1:0]  r_out, w_out_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;

  logic [E-1:0]        w_acc;
  logic [2*E:0]        w_shift;
  logic [E-1:0]        w_m_ext;
  logic [E-1:0]        w_q_ext;

  // Extension bit is the operand MSB in signed mode, zero otherwise
  assign w_m_ext = {bus.sgn & bus.M[WIDTH-1], bus.M};
  assign w_q_ext = {bus.sgn & bus.Q[WIDTH-1], bus.Q};

  // Booth recode of {Qreg[0], q_1}: add, subtract or keep the multiplicand
  always_comb begin
    w_acc = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_acc = r_a + r_m;
      2'b10:   w_acc = r_a - r_m;
      default: w_acc = r_a;
    endcase
  end

  // Arithmetic right shift of {A, Qreg, q_1}; old q_1 drops off the end
  assign w_shift = {w_acc[E-1], w_acc, r_q};

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_m_nxt     = r_m;
    w_q_nxt     = r_q;
    w_q1_nxt    = r_q1;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.input_signal) begin
          w_a_nxt     = '0;
          w_m_nxt     = w_m_ext;
          w_q_nxt     = w_q_ext;
          w_q1_nxt    = 1'b0;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_a_nxt     = w_shift[2*E:E+1];
        w_q_nxt     = w_shift[E:1];
        w_q1_nxt    = w_shift[0];
        w_count_nxt = r_count + CW'(1);
        if (r_count == c_LAST) begin
          // {A,Qreg} after the final shift is the exact product; the low
          // 2*WIDTH bits are exact in both operand modes.
          w_out_nxt   = w_shift[2*WIDTH:1];
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_m     <= w_m_nxt;
      r_q     <= w_q_nxt;
      r_q1    <= w_q1_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire
